// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master port.
package axil_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    // AXI response codes as seen on BRESP/RRESP.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_master_port_if.sv
// AXI4-Lite bus bundle with initiator and target views.
interface axil_master_port_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/axil_lat_counter.sv
// Saturating transaction latency counter with a capture register.
module axil_lat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             capture,
    output logic [CNT_W-1:0] cycles
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cap_q, cap_d;

    // Next count: load restarts at 1, enable counts up and sticks at all-ones.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        cap_d   = cap_q;
        if (load) begin
            count_d = CNT_W'(1);
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
        if (capture) begin
            cap_d = count_q;
        end
    end

    // Counter and captured value registers, synchronous active-low reset.
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            cap_q   <= '0;
        end else begin
            count_q <= count_d;
            cap_q   <= cap_d;
        end
    end

    assign cycles = cap_q;

endmodule

// File: rtl/axil_master_port.sv
// Single-outstanding AXI4-Lite initiator: one local command in, one response out.
module axil_master_port
    import axil_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [CNT_W-1:0]  rsp_cycles,
    axil_master_port_if.master m_axil
);

    state_t            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;

    logic cnt_load, cnt_en, cnt_capture;

    // Sequencer next-state and channel register updates.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        cnt_load    = 1'b0;
        cnt_capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d     = cmd_we;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    wstrb_d  = cmd_wstrb;
                    cnt_load = 1'b1;
                    if (cmd_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // Address and data channels retire independently, in any order.
                if (awvalid_q && m_axil.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axil.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    resp_d      = m_axil.bresp;
                    rdata_d     = '0;
                    rsp_valid_d = 1'b1;
                    cnt_capture = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil.rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rdata_d     = m_axil.rdata;
                    resp_d      = m_axil.rresp;
                    rsp_valid_d = 1'b1;
                    cnt_capture = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    // The count runs from the first request cycle through the B/R handshake cycle.
    assign cnt_en = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_DATA);

    axil_lat_counter #(.CNT_W(CNT_W)) u_lat (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (cnt_en),
        .capture (cnt_capture),
        .cycles  (rsp_cycles)
    );

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_we     = we_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_resp   = resp_q;

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_master_port.sv
// Directed bench for axil_master_port: a modelled register slave plus a
// second CNT_W=4 instance whose slave side is driven step by step.
module tb_axil_master_port;

    logic clk;
    logic rst;

    logic        cmd_valid, cmd_ready, cmd_we;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [15:0] rsp_cycles;

    logic        c4_valid, c4_ready;
    logic        r4_valid, r4_ready, r4_we;
    logic [31:0] r4_rdata;
    logic [1:0]  r4_resp;
    logic [3:0]  r4_cycles;

    int n_assert = 0;
    int n_fail   = 0;

    axil_master_port_if #(.ADDR_W(16), .DATA_W(32)) bus ();
    axil_master_port_if #(.ADDR_W(16), .DATA_W(32)) bus4 ();

    axil_master_port dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_cycles(rsp_cycles),
        .m_axil(bus)
    );

    axil_master_port #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_we(1'b1),
        .cmd_addr(16'h0030), .cmd_wdata(32'h0000_0077), .cmd_wstrb(4'hF),
        .rsp_valid(r4_valid), .rsp_ready(r4_ready), .rsp_we(r4_we),
        .rsp_rdata(r4_rdata), .rsp_resp(r4_resp), .rsp_cycles(r4_cycles),
        .m_axil(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register slave model for dut ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0;
    logic [1:0]  b_resp_k = 2'b00;
    logic        r_err    = 1'b0;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt;
    logic        aw_got, w_got, b_pend;
    logic [15:0] aw_addr_s;
    logic [31:0] w_data_s;
    logic [3:0]  w_strb_s;
    logic [31:0] mem [16];
    logic        aw_hs, w_hs, ar_hs;
    logic [15:0] wr_a;
    logic [31:0] wr_d;
    logic [3:0]  wr_s;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_delay);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;
    assign ar_hs = bus.arvalid && bus.arready;
    assign wr_a  = aw_hs ? bus.awaddr : aw_addr_s;
    assign wr_d  = w_hs  ? bus.wdata  : w_data_s;
    assign wr_s  = w_hs  ? bus.wstrb  : w_strb_s;

    always @(posedge clk) begin
        if (!rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
            bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
        end else begin
            if (aw_hs) begin
                aw_got <= 1'b1; aw_addr_s <= bus.awaddr; aw_cnt <= 0;
            end else if (bus.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_got <= 1'b1; w_data_s <= bus.wdata; w_strb_s <= bus.wstrb; w_cnt <= 0;
            end else if (bus.wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                bus.bresp <= b_resp_k;
                for (int i = 0; i < 4; i++)
                    if (wr_s[i]) mem[wr_a[5:2]][8*i +: 8] <= wr_d[8*i +: 8];
                if (b_delay == 0) bus.bvalid <= 1'b1;
                else b_cnt <= b_delay - 1;
            end else if (b_pend && !bus.bvalid) begin
                if (b_cnt == 0) bus.bvalid <= 1'b1;
                else b_cnt <= b_cnt - 1;
            end
            if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
                b_pend     <= 1'b0;
            end
            if (ar_hs) begin
                ar_cnt     <= 0;
                bus.rvalid <= 1'b1;
                bus.rdata  <= r_err ? 32'hDEAD_BEEF : mem[bus.araddr[5:2]];
                bus.rresp  <= r_err ? 2'b10 : 2'b00;
            end else if (bus.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command and return in the cycle after it was accepted.
    task automatic send(input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
        cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check("cmd_ready_before_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 100 && !rsp_valid; i++) tick();
        check("rsp_valid_arrives", rsp_valid, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", rsp_valid, 0);
        check("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        c4_valid = 1'b0; r4_ready = 1'b0;
        bus4.awready = 1'b1; bus4.wready = 1'b1; bus4.arready = 1'b0;
        bus4.bvalid = 1'b0; bus4.bresp = 2'b00;
        bus4.rvalid = 1'b0; bus4.rresp = 2'b00; bus4.rdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_resp", rsp_resp, 0);
        check("rst_rsp_cycles", rsp_cycles, 0);
        check("rst_awaddr", bus.awaddr, 0);
        rst = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Basic write, zero-wait slave
        send(1'b1, 16'h0004, 32'h0000_1234, 4'hF);
        check("wr_awvalid_rise", bus.awvalid, 1);
        check("wr_wvalid_rise", bus.wvalid, 1);
        check("wr_awaddr", bus.awaddr, 16'h0004);
        check("wr_wdata", bus.wdata, 32'h0000_1234);
        check("wr_wstrb", bus.wstrb, 4'hF);
        check("wr_awprot", bus.awprot, 3'b000);
        check("wr_cmd_ready_busy", cmd_ready, 0);
        wait_rsp();
        check("wr_rsp_we", rsp_we, 1);
        check("wr_rsp_resp", rsp_resp, 2'b00);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_cycles", rsp_cycles, 2);
        take_rsp();

        // Read back
        send(1'b0, 16'h0004, 32'h0, 4'h0);
        check("rd_arvalid_rise", bus.arvalid, 1);
        check("rd_araddr", bus.araddr, 16'h0004);
        wait_rsp();
        check("rd_rsp_we", rsp_we, 0);
        check("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
        check("rd_rsp_resp", rsp_resp, 2'b00);
        check("rd_rsp_cycles", rsp_cycles, 2);
        take_rsp();

        // Partial strobe write (low two bytes), then read back
        send(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'b0011);
        check("strb_wstrb", bus.wstrb, 4'b0011);
        wait_rsp();
        take_rsp();
        send(1'b0, 16'h0004, 32'h0, 4'h0);
        wait_rsp();
        check("strb_readback", rsp_rdata, 32'h0000_FFFF);
        take_rsp();

        // awready delayed 3 cycles, wready immediate
        aw_delay = 3;
        send(1'b1, 16'h0010, 32'hCAFE_0001, 4'hF);
        check("awdly_awvalid_c1", bus.awvalid, 1);
        check("awdly_wvalid_c1", bus.wvalid, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("awdly_awvalid_held", bus.awvalid, 1);
            check("awdly_wvalid_dropped", bus.wvalid, 0);
            check("awdly_bready_low", bus.bready, 0);
            check("awdly_wdata_stable", bus.wdata, 32'hCAFE_0001);
            check("awdly_awaddr_stable", bus.awaddr, 16'h0010);
        end
        tick();
        check("awdly_awvalid_dropped", bus.awvalid, 0);
        check("awdly_bready_rise", bus.bready, 1);
        wait_rsp();
        check("awdly_rsp_cycles", rsp_cycles, 5);
        check("awdly_rsp_resp", rsp_resp, 2'b00);
        take_rsp();
        aw_delay = 0;

        // Error read with response back-pressure
        r_err = 1'b1;
        send(1'b0, 16'h0F00, 32'h0, 4'h0);
        wait_rsp();
        r_err = 1'b0;
        check("err_rsp_resp", rsp_resp, 2'b10);
        check("err_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("bp_rsp_resp", rsp_resp, 2'b10);
            check("bp_rsp_cycles", rsp_cycles, 2);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_arvalid", bus.arvalid, 0);
        end
        take_rsp();

        // DECERR write: response passed through, rdata forced to 0
        b_resp_k = 2'b11;
        send(1'b1, 16'h0020, 32'h0000_0011, 4'hF);
        wait_rsp();
        b_resp_k = 2'b00;
        check("decerr_rsp_resp", rsp_resp, 2'b11);
        check("decerr_rsp_rdata", rsp_rdata, 0);
        take_rsp();

        // Reset while arvalid is waiting for arready
        ar_delay = 100;
        send(1'b0, 16'h0004, 32'h0, 4'h0);
        check("mid_arvalid_high", bus.arvalid, 1);
        check("mid_arready_low", bus.arready, 0);
        rst = 1'b0;
        tick();
        check("mid_rst_arvalid", bus.arvalid, 0);
        check("mid_rst_rready", bus.rready, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_cycles", rsp_cycles, 0);
        rst = 1'b1;
        ar_delay = 0;
        tick();
        check("mid_post_cmd_ready", cmd_ready, 1);
        send(1'b1, 16'h0008, 32'h5A5A_0F0F, 4'hF);
        wait_rsp();
        check("mid_wr_rsp_resp", rsp_resp, 2'b00);
        check("mid_wr_rsp_cycles", rsp_cycles, 2);
        take_rsp();
        send(1'b0, 16'h0008, 32'h0, 4'h0);
        wait_rsp();
        check("mid_rd_rsp_rdata", rsp_rdata, 32'h5A5A_0F0F);
        take_rsp();

        // CNT_W=4 instance: bvalid stalled 20 cycles saturates the count
        check("c4_cmd_ready", c4_ready, 1);
        c4_valid = 1'b1;
        tick();
        c4_valid = 1'b0;
        check("c4_awvalid", bus4.awvalid, 1);
        check("c4_wvalid", bus4.wvalid, 1);
        repeat (20) tick();
        check("c4_bready_waiting", bus4.bready, 1);
        check("c4_rsp_valid_early", r4_valid, 0);
        bus4.bvalid = 1'b1;
        bus4.bresp  = 2'b10;
        tick();
        bus4.bvalid = 1'b0;
        check("c4_rsp_valid", r4_valid, 1);
        check("c4_rsp_cycles_sat", r4_cycles, 4'hF);
        check("c4_rsp_resp", r4_resp, 2'b10);
        check("c4_bready_cleared", bus4.bready, 0);
        r4_ready = 1'b1;
        tick();
        r4_ready = 1'b0;
        check("c4_rsp_valid_cleared", r4_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
